// File: rtl/calc_keypad_seq_if.sv
// Keypad-side bundle for calc_keypad_seq: key levels in, operand display and result flags out.
interface calc_keypad_seq_if #(
  parameter int W = 8
);
  logic [9:0]     digit;
  logic [2:0]     op;
  logic           op_key;
  logic           eq;
  logic           clr;
  logic [W-1:0]   disp;
  logic [2*W-1:0] res;
  logic           res_valid;
  logic           neg;
  logic           err;
  logic [2:0]     state;

  modport master (
    output digit, op, op_key, eq, clr,
    input  disp, res, res_valid, neg, err, state
  );

  modport slave (
    input  digit, op, op_key, eq, clr,
    output disp, res, res_valid, neg, err, state
  );
endinterface

// File: rtl/calc_keypad_seq.sv
// Keypad calculator sequencer: edge-detected keys build decimal operands, then add/sub/mul/and/or
// in one cycle or restoring division at one quotient bit per cycle.
module calc_keypad_seq #(
  parameter int W      = 8,
  parameter int DIGITS = 2
) (
  input logic              clk,
  input logic              rst_n,
  calc_keypad_seq_if.slave kp
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ENTER_A = 3'd1;
  localparam logic [2:0] ENTER_B = 3'd2;
  localparam logic [2:0] CALC    = 3'd3;
  localparam logic [2:0] DIV     = 3'd4;
  localparam logic [2:0] RESULT  = 3'd5;
  localparam logic [2:0] ERROR   = 3'd6;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;

  localparam int CW = $clog2(DIGITS + 1);
  localparam int SW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIGITS);
  localparam logic [SW-1:0] STEP_LAST = SW'(W - 1);

  // key history
  logic [9:0] digit_prev;
  logic       op_key_prev, eq_prev, clr_prev;

  // events
  logic [9:0] dig_new;
  logic       dig_ev, op_ev, eq_ev, clr_ev;
  logic [3:0] dig_val;

  // state and next state
  logic [2:0]     st, st_n;
  logic [W-1:0]   a, a_n, b, b_n;
  logic [CW-1:0]  cnt_a, cnt_a_n, cnt_b, cnt_b_n;
  logic [2:0]     op_r, op_r_n;
  logic [W-1:0]   disp, disp_n;
  logic [2*W-1:0] res, res_n;
  logic           res_valid, res_valid_n, neg, neg_n, err, err_n;
  logic [W-1:0]   rem, rem_n, quot, quot_n, dvs, dvs_n;
  logic [SW-1:0]  step, step_n;

  // datapath helpers
  logic [W-1:0]   a_acc, b_acc;
  logic [W:0]     sh;
  logic           ge;

  always_comb begin
    dig_new = kp.digit & ~digit_prev;
    // exactly one rising key; simultaneous rises are treated as a bounce
    dig_ev  = (dig_new != '0) && ((dig_new & (dig_new - 10'd1)) == '0);
    dig_val = '0;
    for (int i = 0; i < 10; i++)
      if (dig_new[i]) dig_val = 4'(i);
    op_ev  = kp.op_key & ~op_key_prev;
    eq_ev  = kp.eq & ~eq_prev;
    clr_ev = kp.clr & ~clr_prev;
  end

  always_comb begin
    a_acc = a * W'(10) + W'(dig_val);
    b_acc = b * W'(10) + W'(dig_val);
    sh    = {rem, quot[W-1]};
    ge    = sh >= {1'b0, dvs};
  end

  always_comb begin
    st_n        = st;
    a_n         = a;
    b_n         = b;
    cnt_a_n     = cnt_a;
    cnt_b_n     = cnt_b;
    op_r_n      = op_r;
    disp_n      = disp;
    res_n       = res;
    res_valid_n = res_valid;
    neg_n       = neg;
    err_n       = err;
    rem_n       = rem;
    quot_n      = quot;
    dvs_n       = dvs;
    step_n      = step;

    case (st)
      IDLE: begin
        if (dig_ev) begin
          a_n     = W'(dig_val);
          cnt_a_n = CW'(1);
          disp_n  = W'(dig_val);
          st_n    = ENTER_A;
        end else if (op_ev) begin
          a_n     = '0;
          b_n     = '0;
          cnt_b_n = '0;
          op_r_n  = kp.op;
          disp_n  = '0;
          st_n    = ENTER_B;
        end
      end
      ENTER_A: begin
        if (dig_ev) begin
          if (cnt_a < CNT_MAX) begin
            a_n     = a_acc;
            cnt_a_n = cnt_a + CW'(1);
            disp_n  = a_acc;
          end
        end else if (op_ev) begin
          b_n     = '0;
          cnt_b_n = '0;
          op_r_n  = kp.op;
          disp_n  = '0;
          st_n    = ENTER_B;
        end
      end
      ENTER_B: begin
        if (dig_ev) begin
          if (cnt_b < CNT_MAX) begin
            b_n     = b_acc;
            cnt_b_n = cnt_b + CW'(1);
            disp_n  = b_acc;
          end
        end else if (op_ev) begin
          // operator can be corrected only until the second operand starts
          if (cnt_b == '0) op_r_n = kp.op;
        end else if (eq_ev) begin
          st_n = CALC;
        end
      end
      CALC: begin
        neg_n = 1'b0;
        case (op_r)
          OP_ADD: res_n = (2*W)'(a) + (2*W)'(b);
          OP_SUB: begin
            if (a < b) begin
              res_n = (2*W)'(b - a);
              neg_n = 1'b1;
            end else begin
              res_n = (2*W)'(a - b);
            end
          end
          OP_MUL: res_n = (2*W)'(a) * (2*W)'(b);
          OP_AND: res_n = (2*W)'(a & b);
          OP_OR:  res_n = (2*W)'(a | b);
          default: res_n = '0;
        endcase
        if (op_r == OP_DIV) begin
          if (b == '0) begin
            err_n = 1'b1;
            res_n = '0;
            st_n  = ERROR;
          end else begin
            rem_n  = '0;
            quot_n = a;
            dvs_n  = b;
            step_n = '0;
            st_n   = DIV;
          end
        end else if (op_r > OP_OR) begin
          err_n = 1'b1;
          res_n = '0;
          st_n  = ERROR;
        end else begin
          res_valid_n = 1'b1;
          st_n        = RESULT;
        end
      end
      DIV: begin
        // quot doubles as the dividend shift register; quotient bits enter at the LSB
        rem_n  = ge ? W'(sh - {1'b0, dvs}) : sh[W-1:0];
        quot_n = W'({quot, ge});
        if (step == STEP_LAST) begin
          res_n       = {rem_n, quot_n};
          res_valid_n = 1'b1;
          st_n        = RESULT;
        end else begin
          step_n = step + SW'(1);
        end
      end
      RESULT: begin
        if (dig_ev) begin
          res_valid_n = 1'b0;
          neg_n       = 1'b0;
          res_n       = '0;
          a_n         = W'(dig_val);
          cnt_a_n     = CW'(1);
          b_n         = '0;
          cnt_b_n     = '0;
          disp_n      = W'(dig_val);
          st_n        = ENTER_A;
        end
      end
      ERROR: ;
      default: st_n = IDLE;
    endcase

    if (clr_ev) begin
      st_n        = IDLE;
      a_n         = '0;
      b_n         = '0;
      cnt_a_n     = '0;
      cnt_b_n     = '0;
      op_r_n      = '0;
      disp_n      = '0;
      res_n       = '0;
      res_valid_n = 1'b0;
      neg_n       = 1'b0;
      err_n       = 1'b0;
      rem_n       = '0;
      quot_n      = '0;
      dvs_n       = '0;
      step_n      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_prev  <= '0;
      op_key_prev <= 1'b0;
      eq_prev     <= 1'b0;
      clr_prev    <= 1'b0;
      st          <= IDLE;
      a           <= '0;
      b           <= '0;
      cnt_a       <= '0;
      cnt_b       <= '0;
      op_r        <= '0;
      disp        <= '0;
      res         <= '0;
      res_valid   <= 1'b0;
      neg         <= 1'b0;
      err         <= 1'b0;
      rem         <= '0;
      quot        <= '0;
      dvs         <= '0;
      step        <= '0;
    end else begin
      digit_prev  <= kp.digit;
      op_key_prev <= kp.op_key;
      eq_prev     <= kp.eq;
      clr_prev    <= kp.clr;
      st          <= st_n;
      a           <= a_n;
      b           <= b_n;
      cnt_a       <= cnt_a_n;
      cnt_b       <= cnt_b_n;
      op_r        <= op_r_n;
      disp        <= disp_n;
      res         <= res_n;
      res_valid   <= res_valid_n;
      neg         <= neg_n;
      err         <= err_n;
      rem         <= rem_n;
      quot        <= quot_n;
      dvs         <= dvs_n;
      step        <= step_n;
    end
  end

  assign kp.disp      = disp;
  assign kp.res       = res;
  assign kp.res_valid = res_valid;
  assign kp.neg       = neg;
  assign kp.err       = err;
  assign kp.state     = st;
endmodule

// File: tb/tb_calc_keypad_seq.sv
// Directed bench for calc_keypad_seq (W=8, DIGITS=2) with hand-computed expectations.
module tb_calc_keypad_seq;
  logic clk, rst_n;
  int   n_chk, n_fail;
  logic seen;

  calc_keypad_seq_if #(.W(8)) kp();

  calc_keypad_seq #(.W(8), .DIGITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic press_dig(input int d);
    kp.digit = 10'b1 << d;
    @(negedge clk);
    kp.digit = '0;
    @(negedge clk);
  endtask

  task automatic press_op(input logic [2:0] o);
    kp.op     = o;
    kp.op_key = 1'b1;
    @(negedge clk);
    kp.op_key = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_eq();
    kp.eq = 1'b1;
    @(negedge clk);
    kp.eq = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_clr();
    kp.clr = 1'b1;
    @(negedge clk);
    kp.clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    kp.digit = '0; kp.op = '0; kp.op_key = 0; kp.eq = 0; kp.clr = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_state", 32'(kp.state), 0);
    chk("rst_disp", 32'(kp.disp), 0);
    chk("rst_res", 32'(kp.res), 0);
    chk("rst_flags", {29'd0, kp.res_valid, kp.neg, kp.err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 12 + 34
    press_dig(1);
    chk("a1_disp", 32'(kp.disp), 1);
    chk("a1_state", 32'(kp.state), 1);
    press_dig(2);
    chk("a12_disp", 32'(kp.disp), 12);
    press_op(3'b000);
    chk("opkey_state", 32'(kp.state), 2);
    chk("opkey_disp", 32'(kp.disp), 0);
    press_dig(3);
    press_dig(4);
    chk("b34_disp", 32'(kp.disp), 34);
    kp.eq = 1'b1;
    @(negedge clk);
    chk("add_calc", 32'(kp.state), 3);
    chk("add_nvalid", 32'(kp.res_valid), 0);
    kp.eq = 1'b0;
    @(negedge clk);
    chk("add_res", 32'(kp.res), 46);
    chk("add_valid", 32'(kp.res_valid), 1);
    chk("add_neg", 32'(kp.neg), 0);
    chk("add_state", 32'(kp.state), 5);
    @(negedge clk);
    chk("result_hold", 32'(kp.res), 46);

    // 7 - 25 from RESULT
    press_dig(7);
    chk("res2a_state", 32'(kp.state), 1);
    chk("res2a_valid", 32'(kp.res_valid), 0);
    chk("res2a_res", 32'(kp.res), 0);
    chk("res2a_disp", 32'(kp.disp), 7);
    press_op(3'b001);
    press_dig(2);
    press_dig(5);
    press_eq();
    chk("sub_res", 32'(kp.res), 18);
    chk("sub_neg", 32'(kp.neg), 1);

    // 99 * 99 with op correction before B and ignored op after B
    press_dig(9);
    chk("mul_negclr", 32'(kp.neg), 0);
    press_dig(9);
    press_op(3'b000);
    press_op(3'b010);
    press_dig(9);
    press_op(3'b000);
    press_dig(9);
    press_eq();
    chk("mul_res", 32'(kp.res), 9801);
    chk("mul_neg", 32'(kp.neg), 0);

    // 97 / 7
    press_dig(9);
    press_dig(7);
    press_op(3'b011);
    press_dig(7);
    kp.eq = 1'b1;
    @(negedge clk);
    chk("div_calc", 32'(kp.state), 3);
    kp.eq = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("div_busy%0d", i), {28'd0, kp.res_valid, kp.state}, 4);
    end
    @(negedge clk);
    chk("div_res", 32'(kp.res), 32'h060D);
    chk("div_valid", 32'(kp.res_valid), 1);
    chk("div_state", 32'(kp.state), 5);

    // 5 / 0
    press_dig(5);
    press_op(3'b011);
    press_dig(0);
    kp.eq = 1'b1;
    @(negedge clk);
    chk("dz_calc", 32'(kp.state), 3);
    kp.eq = 1'b0;
    @(negedge clk);
    chk("dz_state", 32'(kp.state), 6);
    chk("dz_err", 32'(kp.err), 1);
    chk("dz_res", 32'(kp.res), 0);
    press_dig(3);
    press_eq();
    chk("err_hold_state", 32'(kp.state), 6);
    chk("err_hold_err", 32'(kp.err), 1);
    press_clr();
    chk("clr_state", 32'(kp.state), 0);
    chk("clr_err", 32'(kp.err), 0);

    // invalid op
    press_dig(1);
    press_op(3'b111);
    press_dig(2);
    press_eq();
    chk("inv_err", 32'(kp.err), 1);
    chk("inv_state", 32'(kp.state), 6);
    press_clr();

    // digit limit and simultaneous rises
    press_dig(1);
    kp.digit = 10'b0000011000;
    @(negedge clk);
    kp.digit = '0;
    @(negedge clk);
    chk("multi_rise", 32'(kp.disp), 1);
    press_dig(2);
    press_dig(3);
    chk("digit_limit", 32'(kp.disp), 12);
    press_clr();
    chk("clr_disp", 32'(kp.disp), 0);

    // held key gives one event
    kp.digit = 10'b1 << 5;
    repeat (5) @(negedge clk);
    chk("held_disp", 32'(kp.disp), 5);
    kp.digit = '0;
    @(negedge clk);
    press_dig(6);
    chk("held_next", 32'(kp.disp), 56);
    press_clr();

    // clr aborts a division in its third step
    press_dig(9);
    press_dig(7);
    press_op(3'b011);
    press_dig(7);
    kp.eq = 1'b1;
    @(negedge clk);
    kp.eq = 1'b0;
    @(negedge clk);
    chk("abort_div", 32'(kp.state), 4);
    @(negedge clk);
    @(negedge clk);
    kp.clr = 1'b1;
    @(negedge clk);
    kp.clr = 1'b0;
    chk("abort_state", 32'(kp.state), 0);
    chk("abort_res", 32'(kp.res), 0);
    seen = kp.res_valid;
    repeat (12) begin
      @(negedge clk);
      seen = seen | kp.res_valid;
    end
    chk("abort_novalid", 32'(seen), 0);

    // asynchronous reset during ENTER_B
    press_dig(4);
    press_op(3'b000);
    press_dig(2);
    chk("pre_rst_state", 32'(kp.state), 2);
    chk("pre_rst_disp", 32'(kp.disp), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(kp.state), 0);
    chk("arst_disp", 32'(kp.disp), 0);
    chk("arst_flags", {29'd0, kp.res_valid, kp.neg, kp.err}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_keypad_seq.md
# calc_keypad_seq

Clocked, parametrised keypad calculator sequencer: it takes one-hot decimal key lines, an operator code, and equals/clear keys. It builds multi-digit decimal operands, runs the selected operation (multi-cycle restoring division included) and presents a registered result with valid/error flags. It replaces the single-digit, edge-triggered operand front end and sits between the keypad decoder and the display/result logic.

## Interface
- W, 8: operand width in bits; result width is 2W.
- DIGITS, 2: max decimal digits per operand; requires 10^DIGITS−1 < 2^W.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- digit  in  10  key levels, bit i = decimal digit i.
- op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or; 110/111 invalid.
- op_key  in  1  operator key level; op sampled on its event.
- eq  in  1  equals key level.
- clr  in  1  clear key level.
- disp  out  W  operand currently being entered.
- res  out  2W  result; for div, {remainder, quotient}.
- res_valid  out  1  res holds a completed result.
- neg  out  1  sub result is negative (res holds magnitude).
- err  out  1  divide-by-zero or invalid op.
- state  out  3  FSM state: IDLE 0, ENTER_A 1, ENTER_B 2, CALC 3, DIV 4, RESULT 5, ERROR 6.

## Operation
- Reset (async, rst_n=0): all outputs 0, state IDLE, operands A=B=0, digit counts 0, key-history registers 0.
- Key events: each input is registered once per cycle. An event occurs on a cycle where the current sample is 1 and the previous sample was 0.
- Digit event: the rising set new = digit & ~digit_prev must contain exactly one bit; zero or several rising bits means no event.
- clr event: highest priority in every state. Next edge goes to IDLE with all outputs and operands cleared.
- IDLE: digit → A=d, count 1, ENTER_A. op_key → A=0, latch op, ENTER_B. eq ignored.
- ENTER_A: digit → if count<DIGITS, A=A*10+d and count++; otherwise ignored. op_key → latch op, ENTER_B. eq ignored.
- ENTER_B: digit accumulates B with the same rule. op_key before any B digit → replace the latched op; after a B digit → ignored. eq → CALC.
- CALC, one cycle:
  - invalid op → ERROR, err=1, res=0.
  - div with B=0 → ERROR, err=1, res=0.
  - div, B≠0 → load the divider, go to DIV.
  - any other op → write res, res_valid=1, RESULT.
- Non-div arithmetic:
  - add: zero-extended A+B.
  - sub: |A−B|, with neg=1 when A<B.
  - mul: full 2W-bit A*B.
  - and/or: bitwise on W bits, zero-extended.
- DIV: restoring division, one quotient bit per cycle, MSB first, W cycles. The last cycle writes res={rem,quot}, sets res_valid=1 and goes to RESULT. All keys except clr are ignored in CALC/DIV.
- RESULT: res, neg and res_valid hold. digit → clear res_valid/neg/res, A=d, count 1, B=0, ENTER_A. op_key and eq ignored.
- ERROR: only clr exits. All other keys are ignored; err holds.
- disp: A in IDLE/ENTER_A, B in ENTER_B, unchanged in CALC/DIV/RESULT/ERROR.

## Timing
- A key event is taken on edge k, the first edge sampling the key 1 after a 0 sample. disp and state update after edge k.
- eq event at edge k → CALC after k. res_valid=1 after edge k+1 for non-div ops; err=1 after edge k+1 for error cases.
- div: DIV runs edges k+2 … k+1+W; res_valid=1 after edge k+1+W.
- A key held high produces one event only. Release and press again for another.
- clr and another event on the same edge: clr wins. clr during DIV aborts, with no result written.
- rst_n assertion mid-operation clears everything immediately, without waiting for clk.

## Test plan
- W=8, DIGITS=2: press 1, 2, op=000, 3, 4, eq at edge k → disp 12 then 34; res=46, res_valid after k+1, neg=0.
- Press 7, op=001, 2, 5, eq → res=18, neg=1. Then 9, 9, op=010, 9, 9, eq → res=9801.
- Press 9, 7, op=011, 7, eq at edge k → state DIV for 8 cycles; res=16'h060D (rem 6, quot 13), res_valid after k+9.
- Press 5, op=011, 0, eq → err=1, state ERROR after k+1. digit/eq are then ignored; clr → IDLE, err=0.
- Press 1, 2, 3 → disp=12 (third digit dropped). Digits 3 and 4 rising on the same cycle → no change. Digit held 5 cycles → one event.
- Start a div, assert clr at the third DIV cycle → IDLE next edge, res_valid never asserted. rst_n low mid-ENTER_B → all outputs 0 asynchronously.
